// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register outstanding-write tracker for ID-stage RAW stalls.
// Define SB_WB_BYPASS_EN to treat a same-cycle WB retire as already resolved for stalls.
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int TOT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    input  logic             issue_regwrite_i,
    input  logic [4:0]       issue_rd_i,
    output logic             issue_ready_o,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic             rs1_used_i,
    input  logic             rs2_used_i,
    output logic             stall_o,
    output logic [TOT_W-1:0] pending_cnt_o,
    output logic             err_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;
    logic [CNT_W-1:0] cnt [1:31];
    logic [CNT_W-1:0] cntView [32];
    logic [TOT_W-1:0] tot;
    logic err, rs1Pend, rs2Pend, accept, retire, underflow;
    // x0 has no storage; its view entry is a constant zero
    always_comb begin
        cntView[0] = '0;
        for (int i = 1; i < 32; i++) cntView[i] = cnt[i];
    end
`ifdef SB_WB_BYPASS_EN
    assign rs1Pend = rs1_i != 5'd0 && cntView[rs1_i] != '0 &&
                     !(wb_valid_i && wb_rd_i == rs1_i && cntView[rs1_i] == CNT_W'(1));
    assign rs2Pend = rs2_i != 5'd0 && cntView[rs2_i] != '0 &&
                     !(wb_valid_i && wb_rd_i == rs2_i && cntView[rs2_i] == CNT_W'(1));
`else
    assign rs1Pend = rs1_i != 5'd0 && cntView[rs1_i] != '0;
    assign rs2Pend = rs2_i != 5'd0 && cntView[rs2_i] != '0;
`endif
    assign stall_o       = (rs1_used_i && rs1Pend) || (rs2_used_i && rs2Pend);
    assign issue_ready_o = !stall_o && tot != TOT_MAX &&
                           !(issue_regwrite_i && issue_rd_i != 5'd0 && cntView[issue_rd_i] == CNT_MAX);
    assign accept        = issue_valid_i && issue_ready_o && issue_regwrite_i && issue_rd_i != 5'd0;
    assign retire        = wb_valid_i && wb_rd_i != 5'd0 && cntView[wb_rd_i] != '0;
    assign underflow     = wb_valid_i && wb_rd_i != 5'd0 && cntView[wb_rd_i] == '0;
    assign pending_cnt_o = tot;
    assign err_o         = err;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 1; i < 32; i++) cnt[i] <= '0;
            tot <= '0;
            err <= 1'b0;
        end else begin
            err <= err | underflow;
            if (flush_i) begin
                for (int i = 1; i < 32; i++) cnt[i] <= '0;
                tot <= '0;
            end else begin
                for (int i = 1; i < 32; i++)
                    cnt[i] <= cnt[i] + CNT_W'(accept && issue_rd_i == 5'(i))
                                     - CNT_W'(retire && wb_rd_i == 5'(i));
                tot <= tot + TOT_W'(accept) - TOT_W'(retire);
            end
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and randomized checks of reg_scoreboard against a queue-free array model.
module tb_reg_scoreboard;
    localparam int CNT_W = 2;
    localparam int TOT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;
    localparam int TMAX = (1 << TOT_W) - 1;
`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_i, flush_i, issue_valid_i, issue_regwrite_i, issue_ready_o;
    logic wb_valid_i, rs1_used_i, rs2_used_i, stall_o, err_o;
    logic [4:0] issue_rd_i, wb_rd_i, rs1_i, rs2_i;
    logic [TOT_W-1:0] pending_cnt_o;
    int checks = 0;
    int errors = 0;
    int mc [32];
    int mt;
    bit me;

    reg_scoreboard #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_regwrite_i(issue_regwrite_i),
        .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
        .stall_o(stall_o), .pending_cnt_o(pending_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
        end
    endtask

    function automatic bit mp(input int r);
        return r != 0 && mc[r] > 0 && !(BYP && wb_valid_i && int'(wb_rd_i) == r && mc[r] == 1);
    endfunction

    function automatic bit expStall();
        return (rs1_used_i && mp(int'(rs1_i))) || (rs2_used_i && mp(int'(rs2_i)));
    endfunction

    function automatic bit expReady();
        return !expStall() && mt != TMAX &&
               !(issue_regwrite_i && issue_rd_i != 0 && mc[issue_rd_i] == CMAX);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mc[i] = 0;
        mt = 0;
        me = 0;
    endtask

    task automatic compare();
        chk("stall", 32'(stall_o), 32'(expStall()));
        chk("ready", 32'(issue_ready_o), 32'(expReady()));
        chk("pending", 32'(pending_cnt_o), 32'(mt));
        chk("err", 32'(err_o), 32'(me));
    endtask

    // applies the spec's edge rules to the model using pre-edge state and inputs
    task automatic update();
        bit acc;
        int pre;
        acc = issue_valid_i && expReady() && issue_regwrite_i && issue_rd_i != 0;
        pre = mc[wb_rd_i];
        if (wb_valid_i && wb_rd_i != 0 && pre == 0) me = 1;
        if (flush_i) begin
            for (int i = 0; i < 32; i++) mc[i] = 0;
            mt = 0;
        end else begin
            if (acc) begin
                mc[issue_rd_i]++;
                mt++;
            end
            if (wb_valid_i && wb_rd_i != 0 && pre > 0) begin
                mc[wb_rd_i]--;
                mt--;
            end
        end
    endtask

    task automatic tick();
        #1;
        compare();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    task automatic idle();
        flush_i = 0; issue_valid_i = 0; issue_regwrite_i = 0; issue_rd_i = 0;
        wb_valid_i = 0; wb_rd_i = 0; rs1_i = 0; rs2_i = 0; rs1_used_i = 0; rs2_used_i = 0;
    endtask

    task automatic issue(input int rd);
        issue_valid_i = 1; issue_regwrite_i = 1; issue_rd_i = 5'(rd);
    endtask

    function automatic logic [4:0] rr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        modelReset();
        idle();
        rst_i = 0;
        repeat (2) @(negedge clk);
        rst_i = 1;
        #1;
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_ready", 32'(issue_ready_o), 1);
        chk("rst_pending", 32'(pending_cnt_o), 0);
        chk("rst_err", 32'(err_o), 0);
        // single RAW hazard on x5
        issue(5); tick();
        idle(); rs1_i = 5; rs1_used_i = 1;
        #1;
        chk("raw_stall", 32'(stall_o), 1);
        chk("raw_pending", 32'(pending_cnt_o), 1);
        tick(); tick();
        wb_valid_i = 1; wb_rd_i = 5;
        #1;
        chk("raw_wb_cycle_stall", 32'(stall_o), BYP ? 0 : 1);
        tick();
        wb_valid_i = 0;
        #1;
        chk("raw_after_wb_stall", 32'(stall_o), 0);
        tick();
        // x0 and unused sources
        idle(); issue(0); tick();
        idle();
        #1;
        chk("x0_pending", 32'(pending_cnt_o), 0);
        issue(7); tick();
        idle(); rs2_i = 7;
        #1;
        chk("rs2_unused_stall", 32'(stall_o), 0);
        rs2_used_i = 1;
        #1;
        chk("rs2_used_stall", 32'(stall_o), 1);
        tick();
        idle(); wb_valid_i = 1; wb_rd_i = 7; tick();
        // saturation of x3
        idle(); issue(3);
        repeat (3) tick();
        #1;
        chk("sat_ready", 32'(issue_ready_o), 0);
        chk("sat_pending", 32'(pending_cnt_o), 3);
        tick();
        #1;
        chk("sat_pending_after", 32'(pending_cnt_o), 3);
        idle(); flush_i = 1; tick();
        // simultaneous issue/retire, then flush racing an issue
        idle(); issue(9); tick();
        wb_valid_i = 1; wb_rd_i = 9; tick();
        idle(); rs1_i = 9; rs1_used_i = 1;
        #1;
        chk("sim_stall", 32'(stall_o), 1);
        chk("sim_pending", 32'(pending_cnt_o), 1);
        idle(); flush_i = 1; issue(4); tick();
        idle(); rs1_i = 4; rs1_used_i = 1;
        #1;
        chk("flush_pending", 32'(pending_cnt_o), 0);
        chk("flush_stall", 32'(stall_o), 0);
        tick();
        // underflow is sticky across flush
        idle(); wb_valid_i = 1; wb_rd_i = 12; tick();
        idle();
        #1;
        chk("uf_err", 32'(err_o), 1);
        flush_i = 1; tick();
        idle();
        #1;
        chk("uf_err_after_flush", 32'(err_o), 1);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            flush_i = ($urandom_range(0, 39) == 0);
            issue_valid_i = $urandom_range(0, 1);
            issue_regwrite_i = ($urandom_range(0, 3) != 0);
            issue_rd_i = rr();
            wb_valid_i = ($urandom_range(0, 2) == 0);
            wb_rd_i = rr();
            rs1_i = rr(); rs2_i = rr();
            rs1_used_i = $urandom_range(0, 1);
            rs2_used_i = $urandom_range(0, 1);
            tick();
        end
        // asynchronous reset between edges
        idle(); issue(6); tick(); tick();
        idle();
        #2;
        rst_i = 0;
        #1;
        modelReset();
        chk("arst_pending", 32'(pending_cnt_o), 0);
        chk("arst_err", 32'(err_o), 0);
        chk("arst_ready", 32'(issue_ready_o), 1);
        @(negedge clk);
        rst_i = 1;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
